// File: rtl/conv_filter_scheduler_if.sv
// Control/handshake bundle between layer control, the filter scheduler and the map consumer.
// CONV_SCHED_PERF_EN adds the stall_cycles performance counter output.
interface conv_filter_scheduler_if #(
  parameter int K = 8
);
  localparam int SW = (K > 1) ? $clog2(K) : 1;

  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          eng_reset;
  logic [SW-1:0] filter_sel;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_filter;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]   stall_cycles;

  modport master (
    input  start, abort, out_ready,
    output busy, done, eng_reset, filter_sel, out_valid, out_filter, stall_cycles
  );
  modport slave (
    output start, abort, out_ready,
    input  busy, done, eng_reset, filter_sel, out_valid, out_filter, stall_cycles
  );
`else
  modport master (
    input  start, abort, out_ready,
    output busy, done, eng_reset, filter_sel, out_valid, out_filter
  );
  modport slave (
    output start, abort, out_ready,
    input  busy, done, eng_reset, filter_sel, out_valid, out_filter
  );
`endif
endinterface

// File: rtl/conv_filter_scheduler.sv
// Steps K filters through one shared convolution engine, timing each run and handing each map off via valid/ready.
// Optional macro CONV_SCHED_PERF_EN adds a saturating count of cycles stalled waiting for out_ready.
module conv_filter_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int D          = 1,
  parameter int H          = 48,
  parameter int W          = 48,
  parameter int F          = 3,
  parameter int K          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  conv_filter_scheduler_if.master   bus
);
  localparam int ROW_CYCLES = D * F * F + 3;
  localparam int RUN_CYCLES = (H - F + 1) * ROW_CYCLES;
  localparam int CW         = $clog2(RUN_CYCLES + 1);
  localparam int SW         = (K > 1) ? $clog2(K) : 1;

  generate
    if (DATA_WIDTH < 1 || K < 1 || W < F || H < F) begin : g_param_check
      $error("conv_filter_scheduler: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sel_nxt;
  logic          done_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = bus.filter_sel;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        sel_nxt = '0;
        if (bus.start && !bus.abort) state_nxt = LOAD;
      end
      LOAD: state_nxt = RUN;
      RUN:  if (cnt == CW'(RUN_CYCLES - 1)) state_nxt = WAIT;
      WAIT: begin
        // out_valid is high throughout WAIT, so out_ready alone completes the handshake
        if (bus.out_ready) begin
          if (bus.filter_sel == SW'(K - 1)) begin
            state_nxt = IDLE;
            sel_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = LOAD;
            sel_nxt   = bus.filter_sel + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) begin
      state_nxt = IDLE;
      sel_nxt   = '0;
      done_nxt  = 1'b0;
    end
  end

  // Outputs are registered copies of the decode of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.eng_reset  <= 1'b1;
      bus.filter_sel <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_filter <= '0;
      cnt            <= '0;
    end else begin
      bus.busy       <= (state_nxt != IDLE);
      bus.done       <= done_nxt;
      bus.eng_reset  <= (state_nxt == IDLE) || (state_nxt == LOAD);
      bus.filter_sel <= sel_nxt;
      bus.out_valid  <= (state_nxt == WAIT);
      bus.out_filter <= sel_nxt;
      cnt            <= (state == RUN && state_nxt == RUN) ? cnt + 1'b1 : '0;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.stall_cycles <= '0;
    end else if (state == IDLE && bus.start && !bus.abort) begin
      bus.stall_cycles <= '0;
    end else if (state == WAIT && !bus.out_ready && bus.stall_cycles != 32'hFFFF_FFFF) begin
      bus.stall_cycles <= bus.stall_cycles + 1'b1;
    end
  end
`endif
endmodule
